// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, single-cycle divide corner cases.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        funct_q, funct_d;
  logic [4:0]        dst_q, dst_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;

  logic              sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] acc_n, prod;
  logic [XLEN:0]     sum, tmp;
  logic [XLEN-1:0]   quo, rem, res;

  always_comb begin
    sgn1     = funct inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn2     = funct inside {3'b001, 3'b100, 3'b110};
    neg1     = sgn1 & op1[XLEN-1];
    neg2     = sgn2 & op2[XLEN-1];
    mag1     = neg1 ? -op1 : op1;
    mag2     = neg2 ? -op2 : op2;
    div_zero = op2 == '0;
    div_ovf  = ~funct[0] & (op1 == MIN_NEG) & (op2 == '1);
    fast     = funct[2] & (div_zero | div_ovf);
    if (div_zero) fast_res = funct[1] ? op1 : '1;
    else          fast_res = funct[1] ? '0 : op1;
  end

  // One iteration retires BITS_PER_CYCLE multiplier or quotient bits.
  always_comb begin
    acc_n = acc_q;
    sum   = '0;
    tmp   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (funct_q[2]) begin
        tmp = {acc_n[2*XLEN-1:XLEN], acc_n[XLEN-1]};
        if (tmp >= {1'b0, opb_q}) begin
          sum   = tmp - {1'b0, opb_q};
          acc_n = {sum[XLEN-1:0], acc_n[XLEN-2:0], 1'b1};
        end else begin
          acc_n = {tmp[XLEN-1:0], acc_n[XLEN-2:0], 1'b0};
        end
      end else begin
        sum   = {1'b0, acc_n[2*XLEN-1:XLEN]}
              + (acc_n[0] ? {1'b0, opb_q} : '0);
        acc_n = {sum, acc_n[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = negq_q ? -acc_n : acc_n;
    quo  = negq_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    rem  = negr_q ? -acc_n[2*XLEN-1:XLEN]
                  : acc_n[2*XLEN-1:XLEN];
    unique case (funct_q)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = quo;
      default:                res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    funct_d   = funct_q;
    dst_d     = dst_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        CALC: begin
          acc_d = acc_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d   = FIN;
            done_d    = 1'b1;
            rd_en_d   = dst_q != '0;
            rd_addr_d = dst_q;
            rd_data_d = (dst_q == '0) ? '0 : res;
          end
        end
        default: begin
          // FIN is the done cycle; a new op may start here.
          state_d = IDLE;
          if (en) begin
            funct_d = funct;
            dst_d   = rd_addr_in;
            acc_d   = {{XLEN{1'b0}}, mag1};
            opb_d   = mag2;
            negq_d  = neg1 ^ neg2;
            negr_d  = neg1;
            if (fast) begin
              state_d   = FIN;
              done_d    = 1'b1;
              rd_en_d   = rd_addr_in != '0;
              rd_addr_d = rd_addr_in;
              rd_data_d = (rd_addr_in == '0) ? '0 : fast_res;
            end else begin
              state_d = CALC;
              cnt_d   = CW'(N);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      funct_q   <= '0;
      dst_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      funct_q   <= funct_d;
      dst_q     <= dst_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy    = state_q == CALC;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: two instances (1 and 4 bits per cycle)
// compared every cycle against an operation-level model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0]  rd_addr_in = '0;

  logic [1:0]  busy_w, done_w, rden_w;
  logic [4:0]  addr_w [2];
  logic [31:0] data_w [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .en(en), .funct(funct),
    .op1(op1), .op2(op2), .rd_addr_in(rd_addr_in), .flush(flush),
    .busy(busy_w[0]), .done(done_w[0]), .rd_en(rden_w[0]),
    .rd_addr(addr_w[0]), .rd_data(data_w[0])
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst(rst), .en(en), .funct(funct),
    .op1(op1), .op2(op2), .rd_addr_in(rd_addr_in), .flush(flush),
    .busy(busy_w[1]), .done(done_w[1]), .rd_en(rden_w[1]),
    .rd_addr(addr_w[1]), .rd_data(data_w[1])
  );

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    return f[2] && ((b == 0) ||
      (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Operation-level model: pending result plus cycles left.
  int          nu [2] = '{32, 8};
  int          m_left [2] = '{0, 0};
  logic        m_busy [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic        m_rden [2] = '{1'b0, 1'b0};
  logic [4:0]  m_addr [2] = '{5'd0, 5'd0};
  logic [31:0] m_data [2] = '{32'd0, 32'd0};
  logic [31:0] p_res [2] = '{32'd0, 32'd0};
  logic [4:0]  p_addr [2] = '{5'd0, 5'd0};

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_left[u] = 0;
        m_busy[u] = 0;
        m_done[u] = 0;
        m_rden[u] = 0;
        m_addr[u] = 0;
        m_data[u] = 0;
      end else begin
        m_done[u] = 0;
        m_rden[u] = 0;
        if (flush) begin
          m_left[u] = 0;
        end else if (m_left[u] > 0) begin
          m_left[u]--;
          if (m_left[u] == 0) begin
            m_done[u] = 1;
            m_rden[u] = p_addr[u] != 0;
            m_addr[u] = p_addr[u];
            m_data[u] = (p_addr[u] == 0) ? 32'h0 : p_res[u];
          end
        end else if (en) begin
          p_res[u]  = ref_res(funct, op1, op2);
          p_addr[u] = rd_addr_in;
          if (is_fast(funct, op1, op2)) begin
            m_done[u] = 1;
            m_rden[u] = p_addr[u] != 0;
            m_addr[u] = p_addr[u];
            m_data[u] = (p_addr[u] == 0) ? 32'h0 : p_res[u];
          end else begin
            m_left[u] = nu[u];
          end
        end
        m_busy[u] = m_left[u] > 0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++)
      check($sformatf("cycle u%0d t=%0t", u, $time),
        {24'b0, busy_w[u], done_w[u], rden_w[u], addr_w[u], data_w[u]},
        {24'b0, m_busy[u], m_done[u], m_rden[u], m_addr[u], m_data[u]});
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] ad,
                        input logic [31:0] exp, input bit fst,
                        input string nm);
    int          lat [2];
    logic [31:0] got [2];
    bit          seen [2];
    @(negedge clk);
    en = 1; funct = f; op1 = a; op2 = b; rd_addr_in = ad; flush = 0;
    @(negedge clk);
    en = 0;
    lat = '{0, 0};
    got = '{32'd0, 32'd0};
    seen = '{0, 0};
    for (int i = 1; i <= 40 && !(seen[0] && seen[1]); i++) begin
      for (int u = 0; u < 2; u++)
        if (!seen[u] && done_w[u]) begin
          seen[u] = 1;
          lat[u]  = i;
          got[u]  = data_w[u];
        end
      if (!(seen[0] && seen[1])) @(negedge clk);
    end
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s data u%0d", nm, u), 64'(got[u]), 64'(exp));
      check($sformatf("%s latency u%0d", nm, u), 64'(lat[u]),
            64'(fst ? 1 : nu[u] + 1));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dcount;
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset u0", {24'b0, busy_w[0], done_w[0], rden_w[0],
          addr_w[0], data_w[0]}, 64'h0);
    rst = 0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 0, "MUL");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 0, "MULH");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 0, "MULHU");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 0, "MULHSU");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 0, "DIV");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0, "REM");
    run_op(3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 0, "DIVU");
    run_op(3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 0, "REMU");
    run_op(3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, "DIVU0");
    run_op(3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 1, "REMU0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, "DIVOVF");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1, "REMOVF");
    run_op(3'b000, 32'd6, 32'd7, 5'd0, 32'h0, 0, "X0");

    // In-flight MUL with an ignored en, then flushed.
    @(negedge clk);
    en = 1; funct = 3'b000; op1 = 32'd9; op2 = 32'd9; rd_addr_in = 5'd13;
    @(negedge clk);
    en = 0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    en = 1; funct = 3'b011; op1 = 32'd3; op2 = 32'd4; rd_addr_in = 5'd14;
    @(negedge clk);
    en = 0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush busy", 64'(busy_w), 64'h0);
    check("flush done", 64'(done_w), 64'h0);
    run_op(3'b000, 32'd12, 32'd11, 5'd15, 32'd132, 0, "after flush");

    // Reset in the middle of a divide.
    @(negedge clk);
    en = 1; funct = 3'b101; op1 = 32'd1000; op2 = 32'd3; rd_addr_in = 5'd16;
    @(negedge clk);
    en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst mid u0", {24'b0, busy_w[0], done_w[0], rden_w[0],
          addr_w[0], data_w[0]}, 64'h0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_w != 0) dcount++;
    end
    check("no done after rst", 64'(dcount), 64'h0);

    repeat (600) begin
      @(negedge clk);
      rst        = $urandom_range(0, 299) == 0;
      flush      = $urandom_range(0, 39) == 0;
      en         = $urandom_range(0, 2) == 0;
      funct      = 3'($urandom_range(0, 7));
      op1        = pick();
      op2        = pick();
      rd_addr_in = ($urandom_range(0, 7) == 0) ? 5'd0
                                               : 5'($urandom_range(1, 31));
    end
    @(negedge clk);
    rst = 0; flush = 0; en = 0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
